// File: rtl/ram_player.sv
// ram_player: NCH-channel RAM sample player; load port fills RAMs, start/stop/loop/last_addr drive playback onto data_out/valid with busy/done status
module ram_player #(
  parameter int NCH = 2,
  parameter int WIDTH = 16,
  parameter int RAM_SIZE = 10,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  load_we,
  input  logic [CW-1:0]         load_ch,
  input  logic [RAM_SIZE-1:0]   load_addr,
  input  logic [WIDTH-1:0]      load_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [RAM_SIZE-1:0]   last_addr,
  output logic [NCH*WIDTH-1:0]  data_out,
  output logic                  valid,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
  state_t state, state_nxt;
  logic [RAM_SIZE-1:0] rd_addr, rd_addr_nxt, last_q;
  logic loop_q, issue, issue_q, done_nxt, at_last;
  logic [1:0] cnt, cnt_nxt;
  assign busy = state != IDLE;
  assign at_last = rd_addr == last_q;
  always_comb begin
    state_nxt = state;
    rd_addr_nxt = rd_addr;
    cnt_nxt = cnt;
    issue = 1'b0;
    done_nxt = 1'b0;
    if (state == IDLE) begin
      state_nxt = start ? PLAY : IDLE;
      rd_addr_nxt = start ? '0 : rd_addr;
    end else if (state == PLAY) begin
      cnt_nxt = '0;
      issue = !stop;
      rd_addr_nxt = stop ? rd_addr : at_last ? '0 : rd_addr + 1'b1;
      state_nxt = (stop || (at_last && !loop_q)) ? DRAIN : PLAY;
    end else begin
      cnt_nxt = cnt + 1'b1;
      done_nxt = cnt == 2'd2;
      state_nxt = done_nxt ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_addr <= '0;
      cnt <= '0;
      issue_q <= 1'b0;
      valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= ce && done_nxt;
      if (ce) begin
        state <= state_nxt;
        rd_addr <= rd_addr_nxt;
        cnt <= cnt_nxt;
        issue_q <= issue;
        valid <= issue_q;
        if (state == IDLE && start) begin
          last_q <= last_addr;
          loop_q <= loop;
        end
      end
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] mem [2**RAM_SIZE];
    logic [WIDTH-1:0] q, dq;
    always_ff @(posedge clk) begin
      if (load_we && load_ch == CW'(g)) mem[load_addr] <= load_data;
      if (ce) q <= mem[rd_addr];
    end
    always_ff @(posedge clk) begin
      if (rst) dq <= '0;
      else if (ce) dq <= q;
    end
    assign data_out[g*WIDTH +: WIDTH] = dq;
  end
endmodule

// File: tb/tb_ram_player.sv
// tb_ram_player: randomized self-checking bench for ram_player against a sample-sequence model
module tb_ram_player;
  localparam int NCH = 3, WIDTH = 8, RS = 4, DEPTH = 16;
  logic clk, rst, ce, load_we, start, stop, loop;
  logic [1:0] load_ch;
  logic [RS-1:0] load_addr, last_addr;
  logic [WIDTH-1:0] load_data;
  logic [NCH*WIDTH-1:0] data_out;
  logic valid, busy, done;
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, s_cyc = 0, hold_viol = 0;
  logic done_busy, ce_e, timed_out;
  logic [WIDTH-1:0] mem_m [NCH][DEPTH];
  logic [NCH*WIDTH-1:0] samples [$];
  int vcyc [$];

  ram_player #(.NCH(NCH), .WIDTH(WIDTH), .RAM_SIZE(RS)) dut (
    .clk(clk), .rst(rst), .ce(ce), .load_we(load_we), .load_ch(load_ch),
    .load_addr(load_addr), .load_data(load_data), .start(start), .stop(stop),
    .loop(loop), .last_addr(last_addr), .data_out(data_out), .valid(valid),
    .busy(busy), .done(done));

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ce_e = ce;
    cyc++;
    #1;
    if (ce_e && valid === 1'b1) begin
      samples.push_back(data_out);
      vcyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_busy = busy;
    end
  end

  function automatic logic [NCH*WIDTH-1:0] exp_word(input int a);
    logic [NCH*WIDTH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*WIDTH +: WIDTH] = mem_m[c][a];
    return r;
  endfunction

  task automatic do_load(input int ch, input int a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    load_we = 1; load_ch = 2'(ch); load_addr = RS'(a); load_data = d;
    if (ch < NCH) mem_m[ch][a] = d;
    @(negedge clk);
    load_we = 0;
  endtask

  task automatic run_play(input int last, input bit lp, input int stop_at, input int start_at,
                          input bit tog, input int coll_at, input logic [WIDTH-1:0] coll_val);
    logic pv;
    logic [NCH*WIDTH-1:0] pd;
    samples.delete(); vcyc.delete(); done_cnt = 0; hold_viol = 0;
    @(negedge clk);
    ce = 1; last_addr = RS'(last); loop = lp; start = 1;
    @(posedge clk); #2; s_cyc = cyc;
    @(negedge clk);
    start = 0; last_addr = RS'($urandom); loop = 1'($urandom);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      if (i > 0) @(negedge clk);
      ce = tog ? 1'(i % 2) : 1'b1;
      stop = (i == stop_at);
      start = (i == start_at);
      load_we = (i == coll_at); load_ch = 0; load_addr = 1; load_data = coll_val;
      pv = valid; pd = data_out;
      @(posedge clk); #2;
      if (!ce && (valid !== pv || data_out !== pd)) hold_viol++;
    end
    timed_out = done_cnt == 0;
    @(negedge clk);
    ce = 1; stop = 0; start = 0; load_we = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; ce = 0;
    repeat (3) @(posedge clk);
    #2;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++;
    @(negedge clk);
    rst = 0; ce = 1;
  endtask

  task automatic test_load();
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++)
        do_load(c, a, (c == 0 && a < 8) ? WIDTH'(a + 1) : WIDTH'($urandom));
    do_load(3, 2, 8'hEE);
  endtask

  task automatic test_once();
    run_play(3, 0, -1, -1, 0, -1, 0);
    if (timed_out) begin errors++; $display("FAIL once_timeout: got no done want done"); end
    checks++;
    if (samples.size() != 4) begin errors++; $display("FAIL once_count: got %0d want 4", samples.size()); end
    checks++;
    for (int k = 0; k < samples.size() && k < 4; k++) begin
      if (samples[k] !== exp_word(k)) begin errors++; $display("FAIL once_data%0d: got %h want %h", k, samples[k], exp_word(k)); end
      checks++;
    end
    if (samples.size() > 0) begin
      if (vcyc[0] != s_cyc + 2) begin errors++; $display("FAIL once_latency: got %0d want %0d", vcyc[0] - s_cyc, 2); end
      checks++;
      if (vcyc[vcyc.size()-1] != vcyc[0] + 3) begin errors++; $display("FAIL once_contig: got %0d want %0d", vcyc[vcyc.size()-1], vcyc[0] + 3); end
      checks++;
      if (done_cyc != vcyc[vcyc.size()-1] + 2) begin errors++; $display("FAIL once_done_time: got %0d want %0d", done_cyc, vcyc[vcyc.size()-1] + 2); end
      checks++;
    end
    if (done_cnt != 1) begin errors++; $display("FAIL once_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (done_busy !== 1'b0) begin errors++; $display("FAIL once_busy_at_done: got %b want 0", done_busy); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL once_busy_after: got %b want 0", busy); end
    checks++;
  endtask

  task automatic test_loop();
    int after;
    run_play(2, 1, 10, -1, 0, -1, 0);
    if (timed_out) begin errors++; $display("FAIL loop_timeout: got no done want done"); end
    checks++;
    if (samples.size() < 10) begin errors++; $display("FAIL loop_count: got %0d want >=10", samples.size()); end
    checks++;
    after = 0;
    for (int k = 0; k < samples.size(); k++) begin
      if (samples[k] !== exp_word(k % 3)) begin errors++; $display("FAIL loop_data%0d: got %h want %h", k, samples[k], exp_word(k % 3)); end
      checks++;
      if (vcyc[k] != vcyc[0] + k) begin errors++; $display("FAIL loop_gap%0d: got %0d want %0d", k, vcyc[k], vcyc[0] + k); end
      checks++;
      if (vcyc[k] >= s_cyc + 11) after++;
    end
    if (after > 2) begin errors++; $display("FAIL loop_after_stop: got %0d want <=2", after); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL loop_done_count: got %0d want 1", done_cnt); end
    checks++;
  endtask

  task automatic test_ce();
    run_play(5, 0, -1, -1, 1, -1, 0);
    if (samples.size() != 6) begin errors++; $display("FAIL ce_count: got %0d want 6", samples.size()); end
    checks++;
    for (int k = 0; k < samples.size() && k < 6; k++) begin
      if (samples[k] !== exp_word(k)) begin errors++; $display("FAIL ce_data%0d: got %h want %h", k, samples[k], exp_word(k)); end
      checks++;
    end
    if (hold_viol != 0) begin errors++; $display("FAIL ce_hold: got %0d changes want 0", hold_viol); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ce_done_count: got %0d want 1", done_cnt); end
    checks++;
  endtask

  task automatic test_single();
    run_play(0, 0, -1, 2, 0, -1, 0);
    if (samples.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", samples.size()); end
    checks++;
    if (samples.size() > 0 && samples[0] !== exp_word(0)) begin errors++; $display("FAIL single_data: got %h want %h", samples[0], exp_word(0)); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
    checks++;
  endtask

  task automatic test_full();
    int bad;
    run_play(DEPTH - 1, 0, -1, -1, 0, -1, 0);
    if (samples.size() != DEPTH) begin errors++; $display("FAIL full_count: got %0d want %0d", samples.size(), DEPTH); end
    checks++;
    bad = 0;
    for (int k = 0; k < samples.size() && k < DEPTH; k++) if (samples[k] !== exp_word(k)) bad++;
    if (bad != 0) begin errors++; $display("FAIL full_data: got %0d wrong samples want 0", bad); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] v;
    samples.delete(); done_cnt = 0;
    @(negedge clk);
    last_addr = 7; loop = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    v = WIDTH'($urandom);
    rst = 1; load_we = 1; load_ch = 2; load_addr = 3; load_data = v; mem_m[2][3] = v;
    @(posedge clk); #2;
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++;
    @(negedge clk);
    rst = 0; load_we = 0;
    repeat (6) @(negedge clk);
    if (done_cnt != 0) begin errors++; $display("FAIL mid_rst_done: got %0d pulses want 0", done_cnt); end
    checks++;
    run_play(7, 0, -1, -1, 0, -1, 0);
    if (samples.size() != 8) begin errors++; $display("FAIL mid_replay_count: got %0d want 8", samples.size()); end
    checks++;
    for (int k = 0; k < samples.size() && k < 8; k++) begin
      if (samples[k] !== exp_word(k)) begin errors++; $display("FAIL mid_replay%0d: got %h want %h", k, samples[k], exp_word(k)); end
      checks++;
    end
  endtask

  task automatic test_collision();
    logic [NCH*WIDTH-1:0] w0, old_w, new_w;
    logic [WIDTH-1:0] nv;
    w0 = exp_word(0);
    old_w = exp_word(1);
    nv = mem_m[0][1] ^ 8'h5A;
    run_play(2, 1, 8, -1, 0, 1, nv);
    mem_m[0][1] = nv;
    new_w = exp_word(1);
    if (samples.size() < 8) begin errors++; $display("FAIL coll_count: got %0d want >=8", samples.size()); end
    checks++;
    if (samples.size() >= 8) begin
      if (samples[0] !== w0) begin errors++; $display("FAIL coll_first: got %h want %h", samples[0], w0); end
      checks++;
      if (samples[1] !== old_w) begin errors++; $display("FAIL coll_old: got %h want %h", samples[1], old_w); end
      checks++;
      if (samples[4] !== new_w) begin errors++; $display("FAIL coll_new: got %h want %h", samples[4], new_w); end
      checks++;
      if (samples[7] !== new_w) begin errors++; $display("FAIL coll_new2: got %h want %h", samples[7], new_w); end
      checks++;
    end
  endtask

  initial begin
    rst = 1; ce = 0; load_we = 0; load_ch = 0; load_addr = 0; load_data = 0;
    start = 0; stop = 0; loop = 0; last_addr = 0;
    test_reset();
    test_load();
    test_once();
    test_loop();
    test_ce();
    test_single();
    test_full();
    test_reset_mid();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
